// File: rtl/nn_pkg.sv
// ---------------------------------------------------------------------------
// nn_pkg -- shared definitions for the backpropagation network datapath.
//
// Contents:
//   DWIDTH / AWIDTH  default data and address widths of target memories
//   ONE_Q6_10        1.0 in unsigned Q6.10
//   ZERO_Q6_10       0.0 in unsigned Q6.10
//   state_t          target-writer FSM state type, with IDLE / LOAD / DONE
// ---------------------------------------------------------------------------
package nn_pkg;

  localparam int DWIDTH = 16;
  localparam int AWIDTH = 4;

  localparam logic [15:0] ONE_Q6_10  = 16'h0400;
  localparam logic [15:0] ZERO_Q6_10 = 16'h0000;

  // Plain vector encoding keeps the state codes stable for older tooling
  // that inspects the state register directly.
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t LOAD = 2'd1;
  localparam state_t DONE = 2'd2;

endpackage

// File: rtl/t_writer_if.sv
// ---------------------------------------------------------------------------
// t_writer_if -- load and read bus of the target-value store.
//
// Signals:
//   wr_start, wr_abort       load sequence control (host -> store)
//   s_valid, s_data, s_ready word handshake, Q6.10 data
//   wr_addr                  address the next accepted word goes to
//   done, loaded             load-complete pulse and vector-valid flag
//   rd_en, rd_addr           read request from the training datapath
//   rd_data, rd_valid        registered read response
//
// Modports:
//   master  host / datapath side
//   slave   store side (t_writer)
// ---------------------------------------------------------------------------
interface t_writer_if #(
  parameter int DWIDTH = nn_pkg::DWIDTH,
  parameter int AWIDTH = nn_pkg::AWIDTH
);

  logic              wr_start;
  logic              wr_abort;
  logic              s_valid;
  logic [DWIDTH-1:0] s_data;
  logic              s_ready;
  logic [AWIDTH-1:0] wr_addr;
  logic              done;
  logic              loaded;
  logic              rd_en;
  logic [AWIDTH-1:0] rd_addr;
  logic [DWIDTH-1:0] rd_data;
  logic              rd_valid;

  modport master (
    output wr_start, wr_abort, s_valid, s_data, rd_en, rd_addr,
    input  s_ready, wr_addr, done, loaded, rd_data, rd_valid
  );

  modport slave (
    input  wr_start, wr_abort, s_valid, s_data, rd_en, rd_addr,
    output s_ready, wr_addr, done, loaded, rd_data, rd_valid
  );

endinterface

// File: rtl/t_buf_ram.sv
// ---------------------------------------------------------------------------
// t_buf_ram -- DEPTH x DWIDTH target buffer.
//
// One synchronous write port and one registered read port. A read and a
// write to the same address in the same cycle return the old contents.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   we, waddr, wdata  write port
//   re, raddr         read request
//   rdata, rvalid     read response, one cycle after re; zero when re=0
//
// Build option T_WRITER_ONEHOT_INIT_EN: reset also loads the one-hot
// vector (entry 0 = 1.0, all others 0). Without it the array has no reset.
// ---------------------------------------------------------------------------
module t_buf_ram
  import nn_pkg::*;
#(
  parameter int DWIDTH = nn_pkg::DWIDTH,
  parameter int AWIDTH = nn_pkg::AWIDTH,
  parameter int DEPTH  = 2 ** AWIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              re,
  input  logic [AWIDTH-1:0] raddr,
  output logic [DWIDTH-1:0] rdata,
  output logic              rvalid
);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [DWIDTH-1:0] rdata_reg;
  logic              rvalid_reg;

`ifdef T_WRITER_ONEHOT_INIT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= (i == 0) ? DWIDTH'(ONE_Q6_10) : DWIDTH'(ZERO_Q6_10);
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end
`endif

  // Nonblocking read samples the array before this edge's write lands,
  // which gives read-before-write on an address collision.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_reg  <= '0;
      rvalid_reg <= 1'b0;
    end else if (re) begin
      rdata_reg  <= mem[raddr];
      rvalid_reg <= 1'b1;
    end else begin
      rdata_reg  <= '0;
      rvalid_reg <= 1'b0;
    end
  end

  assign rdata  = rdata_reg;
  assign rvalid = rvalid_reg;

endmodule

// File: rtl/t_writer.sv
// ---------------------------------------------------------------------------
// t_writer -- write side of the target-value store.
//
// Loads DEPTH Q6.10 target words, one per s_valid/s_ready handshake, into
// sequential buffer addresses after a wr_start, and serves the training
// datapath through a registered read port.
//
// Ports:
//   clk    clock, all logic on posedge
//   rst_n  synchronous active-low reset
//   bus    t_writer_if.slave (load control, word handshake, read port)
//
// Build option T_WRITER_ONEHOT_INIT_EN: reset preloads the one-hot vector
// and reports it as loaded.
// ---------------------------------------------------------------------------
module t_writer
  import nn_pkg::*;
#(
  parameter int DWIDTH = nn_pkg::DWIDTH,
  parameter int AWIDTH = nn_pkg::AWIDTH,
  parameter int DEPTH  = 2 ** AWIDTH
) (
  input  logic      clk,
  input  logic      rst_n,
  t_writer_if.slave bus
);

`ifdef T_WRITER_ONEHOT_INIT_EN
  localparam logic LOADED_RST = 1'b1;
`else
  localparam logic LOADED_RST = 1'b0;
`endif

  state_t            state_reg;
  logic [AWIDTH-1:0] wr_addr_reg;
  logic              loaded_reg;
  logic              buf_we;

  // Abort discards a same-cycle word; reset also blocks the write so a
  // word presented during reset never lands.
  assign buf_we = (state_reg == LOAD) && bus.s_valid && !bus.wr_abort && rst_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      wr_addr_reg <= '0;
      loaded_reg  <= LOADED_RST;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.wr_start) begin
            state_reg   <= LOAD;
            wr_addr_reg <= '0;
            loaded_reg  <= 1'b0;
          end
        end
        LOAD: begin
          if (bus.wr_abort) begin
            state_reg   <= IDLE;
            wr_addr_reg <= '0;
          end else if (bus.s_valid) begin
            // Increment wraps to 0 after the last entry.
            wr_addr_reg <= wr_addr_reg + 1'b1;
            if (wr_addr_reg == '1) begin
              state_reg <= DONE;
            end
          end
        end
        DONE: begin
          loaded_reg <= 1'b1;
          state_reg  <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.s_ready = (state_reg == LOAD);
  assign bus.done    = (state_reg == DONE);
  assign bus.wr_addr = wr_addr_reg;
  assign bus.loaded  = loaded_reg;

  t_buf_ram #(
    .DWIDTH(DWIDTH),
    .AWIDTH(AWIDTH),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (buf_we),
    .waddr (wr_addr_reg),
    .wdata (bus.s_data),
    .re    (bus.rd_en),
    .raddr (bus.rd_addr),
    .rdata (bus.rd_data),
    .rvalid(bus.rd_valid)
  );

endmodule

// File: tb/tb_t_writer.sv
// ---------------------------------------------------------------------------
// tb_t_writer -- directed self-checking bench for t_writer.
// Inputs change 1 time unit after posedge; outputs are checked there too.
// ---------------------------------------------------------------------------
module tb_t_writer;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  t_writer_if #(.DWIDTH(16), .AWIDTH(4)) bus ();

  t_writer dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef T_WRITER_ONEHOT_INIT_EN
  localparam logic EXP_LOADED_RST = 1'b1;
`else
  localparam logic EXP_LOADED_RST = 1'b0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wr_start = 1'b0;
    bus.wr_abort = 1'b0;
    bus.s_valid  = 1'b0;
    bus.s_data   = 16'h0000;
    bus.rd_en    = 1'b0;
    bus.rd_addr  = 4'd0;
  endtask

  // Single read: issue rd_en for one edge, return data and valid.
  task automatic do_read(input logic [3:0] addr, output logic [15:0] data,
                         output logic vld);
    bus.rd_en   = 1'b1;
    bus.rd_addr = addr;
    tick();
    data        = bus.rd_data;
    vld         = bus.rd_valid;
    bus.rd_en   = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] d;
    logic        v;
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    checks++;
    if (bus.s_ready !== 1'b0 || bus.done !== 1'b0 || bus.rd_valid !== 1'b0 ||
        bus.rd_data !== 16'h0000 || bus.wr_addr !== 4'd0) begin
      errors++;
      $display("FAIL reset_outputs: s_ready=%b done=%b rd_valid=%b rd_data=%h wr_addr=%0d required 0 0 0 0000 0",
               bus.s_ready, bus.done, bus.rd_valid, bus.rd_data, bus.wr_addr);
    end
    checks++;
    if (bus.loaded !== EXP_LOADED_RST) begin
      errors++;
      $display("FAIL reset_loaded: got %b required %b", bus.loaded, EXP_LOADED_RST);
    end
`ifdef T_WRITER_ONEHOT_INIT_EN
    do_read(4'd0, d, v);
    checks++;
    if (d !== 16'h0400 || v !== 1'b1) begin
      errors++;
      $display("FAIL reset_onehot_addr0: got %h/%b required 0400/1", d, v);
    end
    do_read(4'd5, d, v);
    checks++;
    if (d !== 16'h0000 || v !== 1'b1) begin
      errors++;
      $display("FAIL reset_onehot_addr5: got %h/%b required 0000/1", d, v);
    end
`else
    d = 16'h0000;
    v = 1'b0;
`endif
    $display("reset: s_ready=%b loaded=%b done=%b rd_valid=%b d=%h v=%b",
             bus.s_ready, bus.loaded, bus.done, bus.rd_valid, d, v);
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_w;
    logic [15:0] d;
    logic        v;
    int          pulses;
    bus.wr_start = 1'b1;
    tick();
    bus.wr_start = 1'b0;
    checks++;
    if (bus.s_ready !== 1'b1 || bus.wr_addr !== 4'd0 || bus.loaded !== 1'b0) begin
      errors++;
      $display("FAIL b2b_enter_load: s_ready=%b wr_addr=%0d loaded=%b required 1 0 0",
               bus.s_ready, bus.wr_addr, bus.loaded);
    end
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = (i == 0) ? 16'h0400 : 16'(i);
      tick();
      if (bus.done === 1'b1) pulses++;
      checks++;
      if (bus.done !== (i == 15)) begin
        errors++;
        $display("FAIL b2b_done_cycle%0d: got %b required %b", i + 2, bus.done, (i == 15));
      end
    end
    bus.s_valid = 1'b0;
    checks++;
    if (bus.s_ready !== 1'b0 || bus.wr_addr !== 4'd0) begin
      errors++;
      $display("FAIL b2b_done_state: s_ready=%b wr_addr=%0d required 0 0", bus.s_ready, bus.wr_addr);
    end
    tick();
    if (bus.done === 1'b1) pulses++;
    checks++;
    if (bus.loaded !== 1'b1 || pulses != 1) begin
      errors++;
      $display("FAIL b2b_loaded: loaded=%b pulses=%0d required 1 1", bus.loaded, pulses);
    end
    for (int i = 0; i < 16; i++) begin
      exp_w = (i == 0) ? 16'h0400 : 16'(i);
      do_read(4'(i), d, v);
      checks++;
      if (d !== exp_w || v !== 1'b1) begin
        errors++;
        $display("FAIL b2b_read%0d: got %h/%b required %h/1", i, d, v, exp_w);
      end
      $display("b2b read addr=%0d data=%h valid=%b", i, d, v);
    end
    tick();
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.rd_data !== 16'h0000) begin
      errors++;
      $display("FAIL b2b_rd_idle: got %h/%b required 0000/0", bus.rd_data, bus.rd_valid);
    end
  endtask

  task automatic test_toggle_valid();
    logic [3:0]  exp_addr;
    logic [15:0] d;
    logic        v;
    bus.wr_start = 1'b1;
    tick();
    bus.wr_start = 1'b0;
    exp_addr = 4'd0;
    for (int c = 0; c < 32; c++) begin
      bus.s_valid = (c % 2 == 0);
      bus.s_data  = 16'h1000 + 16'(c / 2);
      if (c % 2 == 1) bus.s_data = 16'hFFFF;
      tick();
      if (c % 2 == 0) exp_addr = exp_addr + 4'd1;
      checks++;
      if (bus.wr_addr !== exp_addr || bus.done !== (c == 30)) begin
        errors++;
        $display("FAIL toggle_c%0d: wr_addr=%0d done=%b required %0d %b",
                 c, bus.wr_addr, bus.done, exp_addr, (c == 30));
      end
    end
    bus.s_valid = 1'b0;
    checks++;
    if (bus.loaded !== 1'b1) begin
      errors++;
      $display("FAIL toggle_loaded: got %b required 1", bus.loaded);
    end
    do_read(4'd7, d, v);
    checks++;
    if (d !== 16'h1007) begin
      errors++;
      $display("FAIL toggle_read7: got %h required 1007", d);
    end
    do_read(4'd15, d, v);
    checks++;
    if (d !== 16'h100F) begin
      errors++;
      $display("FAIL toggle_read15: got %h required 100f", d);
    end
    $display("toggle: loaded=%b addr15=%h", bus.loaded, d);
  endtask

  task automatic test_abort();
    logic [15:0] d;
    logic        v;
    bus.wr_start = 1'b1;
    tick();
    bus.wr_start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 16'h2000 + 16'(i);
      tick();
    end
    bus.wr_abort = 1'b1;
    bus.s_data   = 16'hDEAD;
    tick();
    bus.wr_abort = 1'b0;
    bus.s_valid  = 1'b0;
    checks++;
    if (bus.s_ready !== 1'b0 || bus.wr_addr !== 4'd0 || bus.loaded !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL abort_state: s_ready=%b wr_addr=%0d loaded=%b done=%b required 0 0 0 0",
               bus.s_ready, bus.wr_addr, bus.loaded, bus.done);
    end
    do_read(4'd7, d, v);
    checks++;
    if (d !== 16'h1007) begin
      errors++;
      $display("FAIL abort_discard: got %h required 1007", d);
    end
    do_read(4'd6, d, v);
    checks++;
    if (d !== 16'h2006) begin
      errors++;
      $display("FAIL abort_kept6: got %h required 2006", d);
    end
    bus.wr_start = 1'b1;
    tick();
    bus.wr_start = 1'b0;
    checks++;
    if (bus.s_ready !== 1'b1 || bus.wr_addr !== 4'd0) begin
      errors++;
      $display("FAIL abort_restart: s_ready=%b wr_addr=%0d required 1 0", bus.s_ready, bus.wr_addr);
    end
    for (int i = 0; i < 2; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 16'h3000 + 16'(i);
      tick();
    end
    bus.s_valid  = 1'b0;
    bus.wr_start = 1'b1;
    tick();
    bus.wr_start = 1'b0;
    checks++;
    if (bus.wr_addr !== 4'd2 || bus.s_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_ignored: wr_addr=%0d s_ready=%b required 2 1", bus.wr_addr, bus.s_ready);
    end
    for (int i = 2; i < 16; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 16'h3000 + 16'(i);
      tick();
    end
    bus.s_valid = 1'b0;
    checks++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL abort_reload_done: got %b required 1", bus.done);
    end
    tick();
    $display("abort: reload complete loaded=%b", bus.loaded);
  endtask

  task automatic test_read_before_write();
    bus.wr_start = 1'b1;
    tick();
    bus.wr_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 16'h4000 + 16'(i);
      tick();
    end
    bus.s_data  = 16'hABCD;
    bus.rd_en   = 1'b1;
    bus.rd_addr = 4'd3;
    tick();
    bus.s_valid = 1'b0;
    checks++;
    if (bus.rd_data !== 16'h3003 || bus.rd_valid !== 1'b1) begin
      errors++;
      $display("FAIL rbw_old: got %h/%b required 3003/1", bus.rd_data, bus.rd_valid);
    end
    tick();
    checks++;
    if (bus.rd_data !== 16'hABCD) begin
      errors++;
      $display("FAIL rbw_new: got %h required abcd", bus.rd_data);
    end
    bus.rd_en    = 1'b0;
    bus.wr_abort = 1'b1;
    tick();
    bus.wr_abort = 1'b0;
    $display("rbw: read-after-write addr3=abcd, aborted s_ready=%b", bus.s_ready);
  endtask

  task automatic test_reset_mid_load();
    logic [15:0] d;
    logic        v;
    int          pulses;
    bus.wr_start = 1'b1;
    tick();
    bus.wr_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 16'h5000 + 16'(i);
      tick();
    end
    bus.s_data = 16'h5555;
    rst_n      = 1'b0;
    tick();
    rst_n = 1'b1;
    pulses = 0;
    checks++;
    if (bus.s_ready !== 1'b0 || bus.loaded !== EXP_LOADED_RST || bus.wr_addr !== 4'd0) begin
      errors++;
      $display("FAIL midrst_state: s_ready=%b loaded=%b wr_addr=%0d required 0 %b 0",
               bus.s_ready, bus.loaded, bus.wr_addr, EXP_LOADED_RST);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.done === 1'b1) pulses++;
    end
    bus.s_valid = 1'b0;
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL midrst_no_done: got %0d pulses required 0", pulses);
    end
    do_read(4'd9, d, v);
    checks++;
`ifdef T_WRITER_ONEHOT_INIT_EN
    if (d !== 16'h0000) begin
      errors++;
      $display("FAIL midrst_read9: got %h required 0000", d);
    end
`else
    if (d !== 16'h5009) begin
      errors++;
      $display("FAIL midrst_read9: got %h required 5009", d);
    end
`endif
    do_read(4'd10, d, v);
    checks++;
`ifdef T_WRITER_ONEHOT_INIT_EN
    if (d !== 16'h0000) begin
      errors++;
      $display("FAIL midrst_read10: got %h required 0000", d);
    end
`else
    if (d !== 16'h300A) begin
      errors++;
      $display("FAIL midrst_read10: got %h required 300a", d);
    end
`endif
    $display("midrst: loaded=%b done_pulses=%0d addr10=%h", bus.loaded, pulses, d);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle_inputs();
    #1;
    test_reset();
    test_back_to_back();
    test_toggle_valid();
    test_abort();
    test_read_before_write();
    test_reset_mid_load();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
